// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with one shared period counter.
// Programmable period and per-channel duty, edge- or center-aligned.
// Writes land in shadow registers and commit only at a period boundary,
// or on every clock while the generator is stopped.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                run enable
//   wr_en/sel/data    shadow write: sel<NUM_CH duty[sel], sel==NUM_CH period
//   mode_center       0 edge-aligned, 1 center-aligned (sampled at commit)
//   pwm_out           registered PWM outputs, bit i = channel i
//   period_start      pulse on the first output cycle of each period
module pwm_multi_channel #(
    parameter int NUM_CH         = 4,
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 99,
    localparam int SEL_W         = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              mode_center,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0]  sh_per_q;
    logic [WIDTH-1:0]  sh_duty_q [NUM_CH];
    logic [WIDTH-1:0]  per_q;
    logic [WIDTH-1:0]  duty_q [NUM_CH];
    logic              mode_q;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              ps_q, ps_d;
    logic              commit;

    // Counter next state. dir_q=1 means counting down (center mode only).
    // Comparing against P before stepping keeps cnt within 0..P.
    always_comb begin
        cnt_d = '0;
        dir_d = 1'b0;
        if (en && per_q != '0) begin
            if (mode_q && dir_q) begin
                cnt_d = cnt_q - ONE;
                dir_d = 1'b1;
            end else if (cnt_q < per_q) begin
                cnt_d = cnt_q + ONE;
            end else if (mode_q) begin
                cnt_d = per_q - ONE;
                dir_d = 1'b1;
            end
        end
        // Returning to 0 starts a new period, always counting up.
        if (cnt_d == '0) dir_d = 1'b0;
    end

    // Stopped: load every cycle. Running: load only when a period begins.
    assign commit = !en || (cnt_d == '0);

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = en & (cnt_q < duty_q[i]);
        end
        ps_d = en & (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_per_q <= DEF_P;
            per_q    <= DEF_P;
            for (int i = 0; i < NUM_CH; i++) begin
                sh_duty_q[i] <= '0;
                duty_q[i]    <= '0;
            end
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            pwm_q    <= '0;
            ps_q     <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_sel == SEL_W'(NUM_CH)) sh_per_q <= wr_data;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (wr_sel == SEL_W'(i)) sh_duty_q[i] <= wr_data;
                end
            end
            // Shadow values sampled here predate this edge's write,
            // so a write coinciding with a commit waits a period.
            if (commit) begin
                per_q  <= sh_per_q;
                duty_q <= sh_duty_q;
                mode_q <= mode_center;
            end
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            pwm_q <= pwm_d;
            ps_q  <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel (NUM_CH=2, WIDTH=8).
// Driver queues the expected outputs per edge; monitor compares.
module tb_pwm_multi_channel;

    localparam int NCH = 2;
    localparam int W   = 8;
    localparam int DP  = 99;
    localparam int SW  = $clog2(NCH + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           wr_en;
    logic [SW-1:0]  wr_sel;
    logic [W-1:0]   wr_data;
    logic           mode_center;
    logic [NCH-1:0] pwm_out;
    logic           period_start;

    always #5 clk = ~clk;

    pwm_multi_channel #(
        .NUM_CH(NCH),
        .WIDTH(W),
        .DEFAULT_PERIOD(DP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .wr_en(wr_en),
        .wr_sel(wr_sel),
        .wr_data(wr_data),
        .mode_center(mode_center),
        .pwm_out(pwm_out),
        .period_start(period_start)
    );

    typedef struct {
        logic [NCH-1:0] pwm;
        logic           ps;
        int             tag;
        int             cyc;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int checks   = 0;
    int failures = 0;
    int tag      = 0;
    int cyc      = 0;

    // Expected-behaviour state: position within the current period,
    // the regime in force, and the pending shadow values.
    int pos;
    int cur_p, cur_m;
    int cur_d[NCH];
    int sh_p;
    int sh_d[NCH];

    task automatic step(input bit we, input int sel, input int data);
        exp_t x;
        int   c, len;
        rst     = rst;
        wr_en   = we;
        wr_sel  = SW'(sel);
        wr_data = W'(data);
        x.tag = tag;
        x.cyc = cyc;
        x.pwm = '0;
        x.ps  = 1'b0;
        if (rst) begin
            cur_p = DP; sh_p = DP; cur_m = 0; pos = 0;
            for (int i = 0; i < NCH; i++) begin
                cur_d[i] = 0; sh_d[i] = 0;
            end
        end else begin
            if (!en) begin
                cur_p = sh_p; cur_d = sh_d;
                cur_m = int'(mode_center); pos = 0;
            end else begin
                if (cur_m != 0 && pos > cur_p) c = 2 * cur_p - pos;
                else c = pos;
                if (cur_m != 0) len = (cur_p == 0) ? 1 : 2 * cur_p;
                else len = cur_p + 1;
                for (int i = 0; i < NCH; i++) x.pwm[i] = (c < cur_d[i]);
                x.ps = (pos == 0);
                pos++;
                if (pos == len) begin
                    pos = 0; cur_p = sh_p; cur_d = sh_d;
                    cur_m = int'(mode_center);
                end
            end
            if (we) begin
                if (sel < NCH) sh_d[sel] = data;
                else if (sel == NCH) sh_p = data;
            end
        end
        q.push_back(x);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 0, 0);
    endtask

    task automatic wr(input int sel, input int data);
        step(1'b1, sel, data);
    endtask

    task automatic run_to(input int p);
        int guard;
        guard = 0;
        while (pos != p && guard < 600) begin
            step(1'b0, 0, 0);
            guard++;
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mx = q.pop_front();
            checks++;
            if (pwm_out !== mx.pwm || period_start !== mx.ps) begin
                failures++;
                $display("FAIL t%0d cyc=%0d got pwm=%b ps=%b want pwm=%b ps=%b",
                         mx.tag, mx.cyc, pwm_out, period_start,
                         mx.pwm, mx.ps);
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; en = 1'b1; mode_center = 1'b0;
        wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        tag = 1;
        run(3);
        rst = 1'b0;
        run(250);
        wr(3, 5);
        run(60);

        tag = 2;
        wr(0, 25);
        run(220);

        tag = 3;
        run_to(40);
        wr(0, 50);
        run(230);

        tag = 4;
        wr(0, 0);
        wr(1, 255);
        run(350);

        tag = 5;
        wr(2, 10);
        wr(0, 4);
        mode_center = 1'b1;
        run(130);
        wr(2, 1);
        run(12);
        wr(2, 0);
        run(12);
        mode_center = 1'b0;
        wr(2, 99);
        wr(0, 25);
        wr(1, 0);
        run(150);

        tag = 6;
        run_to(57);
        en = 1'b0;
        wr(1, 60);
        run(3);
        en = 1'b1;
        run(220);
        run_to(57);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(150);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain left=%0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
